// File: rtl/utils_mul_booth_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, LSB digit first.
// Valid/ready operand beat in; product held in DONE until the consumer takes it.
module utils_mul_booth_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            as,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] product,
    output logic            busy
);
    localparam int N  = DW/2 + 1;   // Booth digits in the (DW+2)-bit extended multiplier
    localparam int AW = 2*DW + 4;   // holds any (DW+2)x(DW+2) signed product
    localparam int BW = DW + 3;     // extended multiplier plus the implicit b[-1]
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] a_sh;   // a_ext * 4^i, shifted as digits are consumed
    logic [AW-1:0] acc, acc_nx, pp, addend;
    logic [BW-1:0] b_sh;   // remaining digits; current triplet sits in [2:0]
    logic [CW-1:0] cnt;
    logic [2:0]    trip;
    logic          neg, one, two, last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Booth digit: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1
    assign trip   = b_sh[2:0];
    assign one    = trip[1] ^ trip[0];
    assign two    = (trip == 3'b011) || (trip == 3'b100);
    assign neg    = trip[2] & ~(trip[1] & trip[0]);
    assign pp     = two ? (a_sh << 1) : (one ? a_sh : '0);
    assign addend = neg ? ~pp : pp;
    assign acc_nx = acc + addend + AW'(neg);
    assign last   = (cnt == CW'(N - 1));

    // NOTE: the datapath registers are few and plain flops, so they are all
    // reset; an aborted operation leaves nothing behind after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_sh <= {{(AW-DW){as & a[DW-1]}}, a};
                b_sh <= {{2{as & b[DW-1]}}, b, 1'b0};
                acc  <= '0;
                cnt  <= '0;
            end
        end else if (state == BUSY) begin
            acc  <= acc_nx;
            a_sh <= a_sh << 2;
            b_sh <= b_sh >> 2;
            cnt  <= cnt + CW'(1);
            if (last) product <= acc_nx[2*DW-1:0];
        end
    end
endmodule
